// File: rtl/data_loader.sv
// Bit-serial word entry stage: the operator keys in an nBits word one bit per step press,
// then the block drives the counter's start/ready handshake. Optional macro: DATA_LOADER_DEBOUNCE_EN.
module data_loader #(
    parameter int nBits        = 8,
    parameter int debounceBits = 20,
    parameter int holdBits     = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bitIn,
    input  logic             stepBtn,
    input  logic             clearBtn,
    input  logic             ready,
    output logic             start,
    output logic [nBits-1:0] dataOut,
    output logic [3:0]       bitCount,
    output logic             loading,
    output logic             done
);

    typedef enum logic [1:0] {S_LOAD, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] FULL = 4'(nBits);

    state_t              state_q, state_d;
    logic [nBits-1:0]    data_q, data_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [holdBits-1:0] hold_q, hold_d;
    logic                seen_q, seen_d;
    logic                start_q, loading_q, done_q;

    logic [1:0] stepSync_q, clearSync_q, bitSync_q, readySync_q;
    logic       stepPrev_q, clearPrev_q;
    logic       stepLvl, clearLvl, stepPulse, clearPulse, bitInSync, readySync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stepSync_q  <= '0;
            clearSync_q <= '0;
            bitSync_q   <= '0;
            readySync_q <= '0;
        end else begin
            stepSync_q  <= {stepSync_q[0], stepBtn};
            clearSync_q <= {clearSync_q[0], clearBtn};
            bitSync_q   <= {bitSync_q[0], bitIn};
            readySync_q <= {readySync_q[0], ready};
        end
    end

    assign bitInSync = bitSync_q[1];
    assign readySync = readySync_q[1];

`ifdef DATA_LOADER_DEBOUNCE_EN
    logic                    stepLvl_q, clearLvl_q;
    logic [debounceBits-1:0] stepCnt_q, clearCnt_q;

    // A level is accepted only after it has differed from the held level for 2^debounceBits samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stepLvl_q  <= 1'b0;
            clearLvl_q <= 1'b0;
            stepCnt_q  <= '0;
            clearCnt_q <= '0;
        end else begin
            if (stepSync_q[1] == stepLvl_q) begin
                stepCnt_q <= '0;
            end else if (&stepCnt_q) begin
                stepLvl_q <= stepSync_q[1];
                stepCnt_q <= '0;
            end else begin
                stepCnt_q <= stepCnt_q + 1'b1;
            end
            if (clearSync_q[1] == clearLvl_q) begin
                clearCnt_q <= '0;
            end else if (&clearCnt_q) begin
                clearLvl_q <= clearSync_q[1];
                clearCnt_q <= '0;
            end else begin
                clearCnt_q <= clearCnt_q + 1'b1;
            end
        end
    end

    assign stepLvl  = stepLvl_q;
    assign clearLvl = clearLvl_q;
`else
    assign stepLvl  = stepSync_q[1];
    assign clearLvl = clearSync_q[1];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stepPrev_q  <= 1'b0;
            clearPrev_q <= 1'b0;
        end else begin
            stepPrev_q  <= stepLvl;
            clearPrev_q <= clearLvl;
        end
    end

    assign stepPulse  = stepLvl & ~stepPrev_q;
    assign clearPulse = clearLvl & ~clearPrev_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        hold_d  = '0;
        seen_d  = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (cnt_q == FULL) begin
                    state_d = S_REQ;
                end else if (stepPulse) begin
                    data_d = {data_q[nBits-2:0], bitInSync};
                    cnt_d  = cnt_q + 4'd1;
                end
            end
            S_REQ: begin
                seen_d = seen_q | ~readySync;
                if (&hold_q) begin
                    state_d = S_WAIT;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_WAIT: begin
                seen_d = seen_q | ~readySync;
                if (readySync && seen_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (stepPulse) begin
                    state_d = S_LOAD;
                    data_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_LOAD;
        endcase
        // Clear overrides everything, including a step arriving on the same clock.
        if (clearPulse) begin
            state_d = S_LOAD;
            data_d  = '0;
            cnt_d   = '0;
            hold_d  = '0;
            seen_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_LOAD;
            data_q    <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            seen_q    <= 1'b0;
            start_q   <= 1'b0;
            loading_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            seen_q    <= seen_d;
            start_q   <= (state_d == S_REQ);
            loading_q <= (state_d == S_LOAD);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign start    = start_q;
    assign dataOut  = data_q;
    assign bitCount = cnt_q;
    assign loading  = loading_q;
    assign done     = done_q;

endmodule

// File: tb/tb_data_loader.sv
// Directed bench for data_loader (nBits=8, debounceBits=2, holdBits=3); expected latencies
// follow whether DATA_LOADER_DEBOUNCE_EN is defined for the build.
module tb_data_loader;

`ifdef DATA_LOADER_DEBOUNCE_EN
    localparam int LAT = 7;
    localparam logic [3:0] BOUNCE_CNT  = 4'd1;
    localparam logic [7:0] BOUNCE_DATA = 8'h01;
`else
    localparam int LAT = 3;
    localparam logic [3:0] BOUNCE_CNT  = 4'd6;
    localparam logic [7:0] BOUNCE_DATA = 8'h3F;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       bitIn = 1'b0;
    logic       stepBtn = 1'b0;
    logic       clearBtn = 1'b0;
    logic       ready = 1'b0;
    logic       start;
    logic [7:0] dataOut;
    logic [3:0] bitCount;
    logic       loading;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    data_loader #(.nBits(8), .debounceBits(2), .holdBits(3)) dut (
        .clock(clock), .reset(reset), .bitIn(bitIn), .stepBtn(stepBtn),
        .clearBtn(clearBtn), .ready(ready), .start(start), .dataOut(dataOut),
        .bitCount(bitCount), .loading(loading), .done(done)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press_step(input logic b);
        bitIn = b;
        stepBtn = 1'b1;
        tick(LAT + 2);
        stepBtn = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic press_clear();
        clearBtn = 1'b1;
        tick(LAT + 2);
        clearBtn = 1'b0;
        tick(LAT + 2);
    endtask

    // Presses the n most significant bits of w, MSB first.
    task automatic press_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) press_step(w[7-i]);
    endtask

    task automatic test_reset();
        tick(3);
        vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL rst_start got %b want 0", start); end
        vectors++; if (dataOut !== 8'h00) begin miscompares++; $display("FAIL rst_data got %h want 00", dataOut); end
        vectors++; if (bitCount !== 4'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", bitCount); end
        vectors++; if (loading !== 1'b1) begin miscompares++; $display("FAIL rst_loading got %b want 1", loading); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
        reset = 1'b1;
        tick(2);
        vectors++; if (loading !== 1'b1 || start !== 1'b0 || bitCount !== 4'd0) begin
            miscompares++; $display("FAIL rel_state got load=%b start=%b cnt=%0d want 1 0 0", loading, start, bitCount); end
    endtask

    task automatic test_load();
        bitIn = 1'b1;
        stepBtn = 1'b1;
        tick(LAT - 1);
        vectors++; if (bitCount !== 4'd0) begin miscompares++; $display("FAIL step_early got %0d want 0", bitCount); end
        tick(1);
        vectors++; if (bitCount !== 4'd1) begin miscompares++; $display("FAIL step_latency got %0d want 1", bitCount); end
        tick(2);
        stepBtn = 1'b0;
        tick(LAT + 2);
        press_bits(8'h64, 6);
        vectors++; if (dataOut !== 8'h59 || bitCount !== 4'd7) begin
            miscompares++; $display("FAIL load7 got %h/%0d want 59/7", dataOut, bitCount); end
        bitIn = 1'b0;
        stepBtn = 1'b1;
        tick(LAT);
        stepBtn = 1'b0;
        vectors++; if (dataOut !== 8'hB2 || bitCount !== 4'd8) begin
            miscompares++; $display("FAIL load8 got %h/%0d want B2/8", dataOut, bitCount); end
        vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL start_early got %b want 0", start); end
        tick(1);
        vectors++; if (start !== 1'b1 || loading !== 1'b0) begin
            miscompares++; $display("FAIL start_rise got start=%b load=%b want 1 0", start, loading); end
        for (int i = 2; i <= 8; i++) begin
            tick(1);
            vectors++; if (start !== 1'b1) begin miscompares++; $display("FAIL start_hold%0d got %b want 1", i, start); end
        end
        tick(1);
        vectors++; if (start !== 1'b0 || dataOut !== 8'hB2) begin
            miscompares++; $display("FAIL start_fall got start=%b data=%h want 0 B2", start, dataOut); end
    endtask

    task automatic test_handshake();
        tick(4);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL wait_done got %b want 0", done); end
        ready = 1'b1;
        tick(2);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_early got %b want 0", done); end
        tick(1);
        vectors++; if (done !== 1'b1 || dataOut !== 8'hB2 || bitCount !== 4'd8) begin
            miscompares++; $display("FAIL done_rise got done=%b data=%h cnt=%0d want 1 B2 8", done, dataOut, bitCount); end
        press_step(1'b1);
        vectors++; if (loading !== 1'b1 || done !== 1'b0 || dataOut !== 8'h00 || bitCount !== 4'd0) begin
            miscompares++; $display("FAIL restart got load=%b done=%b data=%h cnt=%0d want 1 0 00 0", loading, done, dataOut, bitCount); end
    endtask

    task automatic test_ready_high();
        press_bits(8'h5A, 8);
        tick(20);
        vectors++; if (done !== 1'b0 || start !== 1'b0 || loading !== 1'b0 || dataOut !== 8'h5A) begin
            miscompares++; $display("FAIL stuck_wait got done=%b start=%b load=%b data=%h want 0 0 0 5A", done, start, loading, dataOut); end
        ready = 1'b0;
        tick(4);
        ready = 1'b1;
        tick(2);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rehs_early got %b want 0", done); end
        tick(1);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rehs_done got %b want 1", done); end
    endtask

    task automatic test_bounce();
        press_step(1'b0);
        vectors++; if (bitCount !== 4'd0 || loading !== 1'b1) begin
            miscompares++; $display("FAIL bounce_pre got cnt=%0d load=%b want 0 1", bitCount, loading); end
        bitIn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stepBtn = (i % 2 == 0);
            tick(1);
        end
        stepBtn = 1'b1;
        tick(LAT + 2);
        stepBtn = 1'b0;
        tick(LAT + 2);
        vectors++; if (bitCount !== BOUNCE_CNT || dataOut !== BOUNCE_DATA) begin
            miscompares++; $display("FAIL bounce got %0d/%h want %0d/%h", bitCount, dataOut, BOUNCE_CNT, BOUNCE_DATA); end
    endtask

    task automatic test_clear();
        press_clear();
        vectors++; if (bitCount !== 4'd0 || dataOut !== 8'h00) begin
            miscompares++; $display("FAIL clear_idle got %0d/%h want 0/00", bitCount, dataOut); end
        press_bits(8'hFF, 5);
        vectors++; if (bitCount !== 4'd5 || dataOut !== 8'h1F) begin
            miscompares++; $display("FAIL load5 got %0d/%h want 5/1F", bitCount, dataOut); end
        bitIn = 1'b1;
        stepBtn = 1'b1;
        clearBtn = 1'b1;
        tick(LAT);
        vectors++; if (bitCount !== 4'd0 || dataOut !== 8'h00 || loading !== 1'b1) begin
            miscompares++; $display("FAIL clr_step got %0d/%h load=%b want 0/00 1", bitCount, dataOut, loading); end
        tick(2);
        stepBtn = 1'b0;
        clearBtn = 1'b0;
        tick(LAT + 2);
        vectors++; if (bitCount !== 4'd0) begin miscompares++; $display("FAIL clr_step_after got %0d want 0", bitCount); end
        // Clear while start is being held.
        press_bits(8'hC3, 7);
        bitIn = 1'b1;
        stepBtn = 1'b1;
        tick(LAT);
        stepBtn = 1'b0;
        tick(1);
        vectors++; if (start !== 1'b1) begin miscompares++; $display("FAIL req_entry got %b want 1", start); end
        clearBtn = 1'b1;
        tick(LAT - 1);
        vectors++; if (start !== 1'b1 || dataOut !== 8'hC3) begin
            miscompares++; $display("FAIL req_hold got start=%b data=%h want 1 C3", start, dataOut); end
        tick(1);
        vectors++; if (start !== 1'b0 || loading !== 1'b1 || bitCount !== 4'd0 || dataOut !== 8'h00) begin
            miscompares++; $display("FAIL req_clear got start=%b load=%b cnt=%0d data=%h want 0 1 0 00", start, loading, bitCount, dataOut); end
        clearBtn = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic test_reset_mid_req();
        press_bits(8'hA5, 7);
        bitIn = 1'b1;
        stepBtn = 1'b1;
        tick(LAT);
        stepBtn = 1'b0;
        tick(3);
        vectors++; if (start !== 1'b1) begin miscompares++; $display("FAIL mid_req got %b want 1", start); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (start !== 1'b0 || dataOut !== 8'h00 || bitCount !== 4'd0 || loading !== 1'b1 || done !== 1'b0) begin
            miscompares++; $display("FAIL async_rst got start=%b data=%h cnt=%0d load=%b done=%b want 0 00 0 1 0", start, dataOut, bitCount, loading, done); end
        tick(2);
        reset = 1'b1;
        tick(12);
        vectors++; if (start !== 1'b0 || loading !== 1'b1 || bitCount !== 4'd0) begin
            miscompares++; $display("FAIL post_rst got start=%b load=%b cnt=%0d want 0 1 0", start, loading, bitCount); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_handshake();
        test_ready_high();
        test_bounce();
        test_clear();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
